// File: rtl/sysid_ext_pkg.sv
// sysid_ext_pkg: shared constants and helpers for the sysid_ext slave.
//   Word offsets of the register map, CONTROL bit positions and a
//   byte-lane merge helper used for byteenable writes.
package sysid_ext_pkg;

    localparam int OFF_ID    = 0;
    localparam int OFF_TS    = 1;
    localparam int OFF_UP_LO = 2;
    localparam int OFF_UP_HI = 3;
    localparam int OFF_CTRL  = 4;
    localparam int OFF_SCR0  = 5;

    localparam int EN_BIT   = 0;
    localparam int CLR_BIT  = 1;
    localparam int LOCK_BIT = 31;

    // Replace only the byte lanes whose enable bit is set.
    function automatic logic [31:0] be_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  be);
        logic [31:0] r;
        r = old_v;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_v[8*b +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/sysid_uptime_counter.sv
// sysid_uptime_counter: 64-bit free-running uptime counter.
//   clock     in   sole clock
//   reset_n   in   synchronous active-low reset
//   en        in   count enable (increment by 1 per cycle)
//   clr       in   zero the counter on the next edge, overrides en
//   snap      in   capture the upper word into hi_shadow this edge
//   cnt_lo    out  live lower 32 bits of the counter
//   hi_shadow out  upper 32 bits as captured by the last snap
module sysid_uptime_counter (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        en,
    input  logic        clr,
    input  logic        snap,
    output logic [31:0] cnt_lo,
    output logic [31:0] hi_shadow
);

    logic [63:0] cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cnt       <= '0;
            hi_shadow <= '0;
        end else begin
            if (clr)
                cnt <= '0;
            else if (en)
                cnt <= cnt + 64'd1;
            // Captured from the same cycle that returns cnt_lo, so the
            // pair read by software is coherent across a lower-word wrap.
            if (snap)
                hi_shadow <= cnt[63:32];
        end
    end

    assign cnt_lo = cnt[31:0];

endmodule

// File: rtl/sysid_ext.sv
// sysid_ext: Avalon-MM system-identification slave.
//   Registers: ID, TIMESTAMP, UPTIME_LO/HI (atomic pair), CONTROL
//   (EN, CLR pulse, sticky LOCK) and N_SCRATCH byte-writable scratch words.
//   clock          in   sole clock
//   reset_n        in   synchronous active-low reset
//   address        in   word address
//   read / write   in   access strobes
//   writedata      in   write data
//   byteenable     in   write byte lanes
//   readdata       out  registered read data (holds when not valid)
//   readdatavalid  out  one-cycle pulse, one cycle after each read
module sysid_ext
    import sysid_ext_pkg::*;
#(
    parameter logic [31:0] ID_VALUE  = 32'h0000_0000,
    parameter logic [31:0] TIMESTAMP = 32'd1436119381,
    parameter int          N_SCRATCH = 4,
    parameter int          ADDR_W    = 5
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              read,
    input  logic              write,
    input  logic [31:0]       writedata,
    input  logic [3:0]        byteenable,
    output logic [31:0]       readdata,
    output logic              readdatavalid
);

    generate
        if (N_SCRATCH < 1 || N_SCRATCH > 16) begin : g_bad_nscratch
            $error("sysid_ext: N_SCRATCH must be in 1..16");
        end
        if (OFF_SCR0 + N_SCRATCH > 2**ADDR_W) begin : g_bad_addr_w
            $error("sysid_ext: ADDR_W too small for the register map");
        end
    endgenerate

    localparam logic [ADDR_W-1:0] A_ID    = ADDR_W'(OFF_ID);
    localparam logic [ADDR_W-1:0] A_TS    = ADDR_W'(OFF_TS);
    localparam logic [ADDR_W-1:0] A_UP_LO = ADDR_W'(OFF_UP_LO);
    localparam logic [ADDR_W-1:0] A_UP_HI = ADDR_W'(OFF_UP_HI);
    localparam logic [ADDR_W-1:0] A_CTRL  = ADDR_W'(OFF_CTRL);

    logic        en_q;
    logic        lock_q;
    logic [31:0] scratch [N_SCRATCH];
    logic [31:0] cnt_lo;
    logic [31:0] hi_shadow;
    logic [31:0] rd_mux;
    logic        wr_ok;
    logic        ctrl_wr;
    logic        ctrl_lane0;
    logic        clr_pulse;
    logic        snap;

    // A write coinciding with a read is dropped with all its side effects.
    assign wr_ok      = write && !read;
    assign ctrl_wr    = wr_ok && (address == A_CTRL);
    assign ctrl_lane0 = ctrl_wr && byteenable[EN_BIT/8] && !lock_q;
    assign clr_pulse  = ctrl_lane0 && writedata[CLR_BIT];
    assign snap       = read && (address == A_UP_LO);

    sysid_uptime_counter u_cnt (
        .clock     (clock),
        .reset_n   (reset_n),
        .en        (en_q),
        .clr       (clr_pulse),
        .snap      (snap),
        .cnt_lo    (cnt_lo),
        .hi_shadow (hi_shadow)
    );

    // lock_q is sampled before this edge, so the write that sets LOCK can
    // still update EN/CLR.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            en_q   <= 1'b1;
            lock_q <= 1'b0;
        end else begin
            if (ctrl_lane0)
                en_q <= writedata[EN_BIT];
            if (ctrl_wr && byteenable[LOCK_BIT/8] && writedata[LOCK_BIT])
                lock_q <= 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < N_SCRATCH; i++) scratch[i] <= '0;
        end else if (wr_ok && !lock_q) begin
            for (int i = 0; i < N_SCRATCH; i++) begin
                if (address == ADDR_W'(OFF_SCR0 + i))
                    scratch[i] <= be_merge(scratch[i], writedata, byteenable);
            end
        end
    end

    always_comb begin
        rd_mux = '0;
        if (address == A_ID)
            rd_mux = ID_VALUE;
        else if (address == A_TS)
            rd_mux = TIMESTAMP;
        else if (address == A_UP_LO)
            rd_mux = cnt_lo;
        else if (address == A_UP_HI)
            rd_mux = hi_shadow;
        else if (address == A_CTRL) begin
            rd_mux[EN_BIT]   = en_q;
            rd_mux[LOCK_BIT] = lock_q;
        end
        for (int i = 0; i < N_SCRATCH; i++) begin
            if (address == ADDR_W'(OFF_SCR0 + i))
                rd_mux = scratch[i];
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read)
                readdata <= rd_mux;
        end
    end

endmodule
